// File: rtl/brlwe_pkg.sv
// Shared defaults and FSM encoding for the BRLWE I/O sequencer.
package brlwe_pkg;

    localparam int N_DEFAULT       = 256;
    localparam int CW_DEFAULT      = 8;
    localparam int TIMEOUT_DEFAULT = 4096;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/brlwe_io_seq_if.sv
// Coefficient stream to the decryption core and its result-bit stream back.
interface brlwe_io_seq_if
    import brlwe_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) ();

    logic          load_o;
    logic          m_bit_o;
    logic [CW-1:0] c1_o;
    logic [CW-1:0] c2_o;
    logic          valid_i;
    logic          m_i;

    modport master (output load_o, m_bit_o, c1_o, c2_o, input valid_i, m_i);
    modport slave  (input load_o, m_bit_o, c1_o, c2_o, output valid_i, m_i);

endinterface

// File: rtl/brlwe_bit_collector.sv
// Gathers result bits from the core into result_o and watches the inter-bit gap.
module brlwe_bit_collector
    import brlwe_pkg::*;
#(
    parameter int  N       = N_DEFAULT,
    parameter int  TIMEOUT = TIMEOUT_DEFAULT,
    localparam int IW      = $clog2(N) + 1,
    localparam int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         clear,
    input  logic         en,
    input  logic         cnt_en,
    input  logic         valid_i,
    input  logic         m_i,
    output logic [N-1:0] result_o,
    output logic         full_o,
    output logic         timeout_o
);

    logic [IW-1:0] out_idx_q, out_idx_d;
    logic [N-1:0]  result_q, result_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          accept;

    always_comb begin
        out_idx_d = out_idx_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        accept    = en && valid_i && (out_idx_q < IW'(N));
        if (clear) begin
            out_idx_d = '0;
            result_d  = '0;
            cnt_d     = '0;
        end else begin
            if (accept) begin
                result_d[out_idx_q[IW-2:0]] = m_i;
                out_idx_d                   = out_idx_q + 1'b1;
            end
            if (cnt_en)
                cnt_d = valid_i ? '0 : (cnt_q == TW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
        end
        // Both flags look one edge ahead so the FSM moves on the same edge.
        full_o    = (out_idx_q == IW'(N)) || (accept && (out_idx_q == IW'(N - 1)));
        timeout_o = cnt_en && !valid_i && (cnt_q >= TW'(TIMEOUT - 1));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_idx_q <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
        end else begin
            out_idx_q <= out_idx_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/brlwe_io_seq.sv
// Streams r2/c1/c2 into the BRLWE core one index per cycle, then collects N result bits.
module brlwe_io_seq
    import brlwe_pkg::*;
#(
    parameter int  N       = N_DEFAULT,
    parameter int  CW      = CW_DEFAULT,
    parameter int  TIMEOUT = TIMEOUT_DEFAULT,
    localparam int IW      = $clog2(N) + 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [N-1:0]      r2_in,
    input  logic [2*N*CW-1:0] c_in,
    brlwe_io_seq_if.master    core,
    output logic [N-1:0]      result_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    state_t        state_q, state_d;
    logic [IW-1:0] in_idx_q, in_idx_d;
    logic          load_q, load_d;
    logic          m_bit_q, m_bit_d;
    logic [CW-1:0] c1_q, c1_d;
    logic [CW-1:0] c2_q, c2_d;
    logic          err_q, err_d;
    logic [IW-2:0] sel;
    logic          accepted, full, timeout;

    always_comb begin
        state_d  = state_q;
        in_idx_d = in_idx_q;
        load_d   = 1'b0;
        m_bit_d  = 1'b0;
        c1_d     = '0;
        c2_d     = '0;
        err_d    = err_q;
        accepted = 1'b0;
        sel      = '0;
        unique case (state_q)
            ST_IDLE: if (start) begin
                accepted = 1'b1;
                err_d    = 1'b0;
                in_idx_d = '0;
                load_d   = 1'b1;
                state_d  = ST_LOAD;
            end
            // in_idx tracks the beat currently on the outputs; the next one is fetched here.
            ST_LOAD: if (in_idx_q == IW'(N - 1)) begin
                state_d = full ? ST_DONE : ST_COLLECT;
            end else begin
                in_idx_d = in_idx_q + 1'b1;
                sel      = in_idx_d[IW-2:0];
                load_d   = 1'b1;
            end
            ST_COLLECT: if (full) begin
                state_d = ST_DONE;
            end else if (timeout) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (load_d) begin
            m_bit_d = r2_in[sel];
            c2_d    = c_in[sel*CW +: CW];
            c1_d    = c_in[N*CW + sel*CW +: CW];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            in_idx_q <= '0;
            load_q   <= 1'b0;
            m_bit_q  <= 1'b0;
            c1_q     <= '0;
            c2_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_idx_q <= in_idx_d;
            load_q   <= load_d;
            m_bit_q  <= m_bit_d;
            c1_q     <= c1_d;
            c2_q     <= c2_d;
            err_q    <= err_d;
        end
    end

    brlwe_bit_collector #(.N(N), .TIMEOUT(TIMEOUT)) u_collector (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (accepted),
        .en        ((state_q == ST_LOAD) || (state_q == ST_COLLECT)),
        .cnt_en    (state_q == ST_COLLECT),
        .valid_i   (core.valid_i),
        .m_i       (core.m_i),
        .result_o  (result_o),
        .full_o    (full),
        .timeout_o (timeout)
    );

    assign core.load_o  = load_q;
    assign core.m_bit_o = m_bit_q;
    assign core.c1_o    = c1_q;
    assign core.c2_o    = c2_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign err_o        = err_q;

endmodule

// File: tb/tb_brlwe_io_seq.sv
// Directed bench: load beats and final results go through scoreboards checked at the negedge.
module tb_brlwe_io_seq;

    localparam int N  = 256;
    localparam int CW = 8;

    typedef struct packed {
        logic          m;
        logic [CW-1:0] c1;
        logic [CW-1:0] c2;
    } beat_t;

    logic              clock = 1'b0;
    logic              resetn, start, start_t;
    logic [N-1:0]      r2_in;
    logic [2*N*CW-1:0] c_in;
    logic [N-1:0]      result_o, result_t;
    logic              busy_o, done_o, err_o, busy_t, done_t, err_t;

    brlwe_io_seq_if #(.CW(CW)) cif ();
    brlwe_io_seq_if #(.CW(CW)) tif ();

    brlwe_io_seq #(.N(N), .CW(CW), .TIMEOUT(4096)) dut (
        .clock(clock), .resetn(resetn), .start(start), .r2_in(r2_in), .c_in(c_in),
        .core(cif), .result_o(result_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    brlwe_io_seq #(.N(N), .CW(CW), .TIMEOUT(16)) dut_t (
        .clock(clock), .resetn(resetn), .start(start_t), .r2_in(r2_in), .c_in(c_in),
        .core(tif), .result_o(result_t), .busy_o(busy_t), .done_o(done_t), .err_o(err_t)
    );

    always #5 clock = ~clock;

    beat_t        beat_q[$];
    logic [N-1:0] res_q[$];
    beat_t        exp_b;
    int           passed = 0, failed = 0, total = 0;
    int           done_cnt = 0, done_t_cnt = 0;
    logic [N-1:0] exp_r, pat;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic new_data();
        for (int i = 0; i < N; i++) r2_in[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 2 * N; i++) c_in[i*CW +: CW] = CW'($urandom);
    endtask

    task automatic push_beats();
        beat_t b;
        for (int i = 0; i < N; i++) begin
            b.m  = r2_in[i];
            b.c2 = c_in[i*CW +: CW];
            b.c1 = c_in[N*CW + i*CW +: CW];
            beat_q.push_back(b);
        end
    endtask

    // Monitors: every load beat and every done pulse is matched against the scoreboards.
    always @(negedge clock) begin
        if (cif.load_o) begin
            if (beat_q.size() == 0) check("load_extra", N'(cif.load_o), N'(1'b0));
            else begin
                exp_b = beat_q.pop_front();
                check("load_beat", N'({cif.m_bit_o, cif.c1_o, cif.c2_o}), N'(exp_b));
            end
        end
        if (done_o) begin
            done_cnt++;
            if (res_q.size() == 0) check("done_extra", N'(done_o), N'(1'b0));
            else check("result_at_done", result_o, res_q.pop_front());
        end
        if (done_t) done_t_cnt++;
    end

    initial begin
        resetn = 1'b0; start = 1'b0; start_t = 1'b0;
        r2_in = '0; c_in = '0;
        cif.valid_i = 1'b0; cif.m_i = 1'b0;
        tif.valid_i = 1'b0; tif.m_i = 1'b0;
        tick(3);
        check("rst_load", N'(cif.load_o), '0);
        check("rst_busy", N'(busy_o), '0);
        check("rst_done", N'(done_o), '0);
        check("rst_err", N'(err_o), '0);
        check("rst_result", result_o, '0);
        check("rst_t_busy", N'(busy_t), '0);
        resetn = 1'b1;
        tick(6);

        // Op 1: first beat values, load length, alternating result bits after a gap.
        new_data();
        r2_in[0] = 1'b1;
        c_in[0 +: CW] = 8'h5A;
        c_in[N*CW +: CW] = 8'hA5;
        push_beats();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("op1_load_rise", N'(cif.load_o), N'(1'b1));
        check("op1_m0", N'(cif.m_bit_o), N'(1'b1));
        check("op1_c2_0", N'(cif.c2_o), N'(8'h5A));
        check("op1_c1_0", N'(cif.c1_o), N'(8'hA5));
        check("op1_busy", N'(busy_o), N'(1'b1));
        tick(N - 1);
        check("op1_load_last", N'(cif.load_o), N'(1'b1));
        tick(1);
        check("op1_load_fall", N'(cif.load_o), '0);
        check("op1_c1_zero", N'(cif.c1_o), '0);
        check("op1_beats_left", N'(beat_q.size()), '0);
        tick(19);
        for (int k = 0; k < N; k++) exp_r[k] = (k % 2 == 0);
        res_q.push_back(exp_r);
        for (int k = 0; k < N; k++) begin
            cif.valid_i = 1'b1;
            cif.m_i = (k % 2 == 0);
            tick(1);
        end
        cif.valid_i = 1'b0;
        check("op1_done", N'(done_o), N'(1'b1));
        check("op1_result", result_o, {(N/4){4'h5}});
        tick(1);
        check("op1_done_fall", N'(done_o), '0);
        check("op1_busy_fall", N'(busy_o), '0);
        check("op1_done_cnt", N'(done_cnt), N'(1));

        // Op 2: valid strobed through the whole load; done only once load has dropped.
        push_beats();
        res_q.push_back('1);
        start = 1'b1; cif.valid_i = 1'b1; cif.m_i = 1'b1;
        tick(1);
        start = 1'b0;
        check("op2_cleared", result_o, '0);
        tick(N - 1);
        check("op2_load_last", N'(cif.load_o), N'(1'b1));
        check("op2_no_early_done", N'(done_o), '0);
        tick(1);
        check("op2_load_fall", N'(cif.load_o), '0);
        check("op2_done", N'(done_o), N'(1'b1));
        cif.m_i = 1'b0;
        tick(2);
        cif.valid_i = 1'b0;
        check("op2_result_held", result_o, '1);
        check("op2_busy", N'(busy_o), '0);
        check("op2_done_cnt", N'(done_cnt), N'(2));

        // Op 3: a second start during collection must change nothing.
        new_data();
        push_beats();
        for (int k = 0; k < N; k++) pat[k] = 1'($urandom_range(0, 1));
        res_q.push_back(pat);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(N);
        for (int k = 0; k < 10; k++) begin
            cif.valid_i = 1'b1; cif.m_i = pat[k];
            tick(1);
        end
        cif.valid_i = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        exp_r = '0;
        for (int k = 0; k < 10; k++) exp_r[k] = pat[k];
        check("op3_partial", result_o, exp_r);
        check("op3_no_reload", N'(cif.load_o), '0);
        check("op3_busy", N'(busy_o), N'(1'b1));
        for (int k = 10; k < N; k++) begin
            cif.valid_i = 1'b1; cif.m_i = pat[k];
            tick(1);
        end
        cif.valid_i = 1'b0;
        check("op3_done", N'(done_o), N'(1'b1));
        check("op3_result", result_o, pat);
        tick(1);
        check("op3_done_cnt", N'(done_cnt), N'(3));

        // Op 4: asynchronous reset at load beat 100, then a clean run from index 0.
        new_data();
        push_beats();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(100);
        check("op4_mid_load", N'(cif.load_o), N'(1'b1));
        resetn = 1'b0;
        #1;
        check("op4_rst_load", N'(cif.load_o), '0);
        check("op4_rst_outs", N'({cif.m_bit_o, cif.c1_o, cif.c2_o}), '0);
        check("op4_rst_busy", N'(busy_o), '0);
        check("op4_rst_result", result_o, '0);
        beat_q.delete();
        tick(2);
        resetn = 1'b1;
        tick(1);
        new_data();
        push_beats();
        for (int k = 0; k < N; k++) pat[k] = 1'($urandom_range(0, 1));
        res_q.push_back(pat);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("op4_restart_m0", N'(cif.m_bit_o), N'(r2_in[0]));
        tick(N);
        for (int k = 0; k < N; k++) begin
            cif.valid_i = 1'b1; cif.m_i = pat[k];
            tick(1);
        end
        cif.valid_i = 1'b0;
        check("op4_done", N'(done_o), N'(1'b1));
        tick(1);
        check("op4_done_cnt", N'(done_cnt), N'(4));
        check("op4_beats_left", N'(beat_q.size()), '0);

        // Op 5: TIMEOUT=16 instance with a silent core.
        start_t = 1'b1;
        tick(1);
        start_t = 1'b0;
        tick(N);
        check("to_collect_busy", N'(busy_t), N'(1'b1));
        tick(15);
        check("to_still_busy", N'(busy_t), N'(1'b1));
        check("to_no_err_yet", N'(err_t), '0);
        tick(1);
        check("to_err", N'(err_t), N'(1'b1));
        check("to_idle", N'(busy_t), '0);
        tick(3);
        check("to_err_held", N'(err_t), N'(1'b1));
        check("to_no_done", N'(done_t_cnt), '0);
        start_t = 1'b1;
        tick(1);
        start_t = 1'b0;
        check("to_err_cleared", N'(err_t), '0);
        check("to_restart_busy", N'(busy_t), N'(1'b1));
        tick(N + 20);
        check("to_no_done_end", N'(done_t_cnt), '0);
        check("res_q_empty", N'(res_q.size()), '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
